// File: rtl/ffd_pipe_stage.sv
// One elastic register stage: holds a word until the next stage can take it.
// Ready looks forward combinationally, so a full chain can advance in one cycle.
module ffd_pipe_stage #(
  parameter int WIDTH      = 8,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             d_ready,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  input  logic             q_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign d_ready = ~valid_q | q_ready;
  assign q_valid = valid_q;
  assign q_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (d_ready) begin
      valid_d = d_valid;
      // Data only moves with a valid word, so bubbles leave it untouched.
      if (d_valid) data_d = d_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) valid_q <= 1'b0;
    else      valid_q <= valid_d;
  end

  generate
    if (CLEAR_DATA) begin : g_data_clr
      always_ff @(posedge clk) begin
        if (rstn) data_q <= '0;
        else      data_q <= data_d;
      end
    end else begin : g_data_hold
      always_ff @(posedge clk) begin
        if (!rstn) data_q <= data_d;
      end
    end
  endgenerate

endmodule

// File: rtl/ffd_pipe.sv
// Elastic DEPTH-stage delay line with valid/ready backpressure, flush and
// an occupancy count.
module ffd_pipe #(
  parameter int  WIDTH      = 8,
  parameter int  DEPTH      = 4,
  parameter bit  CLEAR_DATA = 1'b1,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level
);

  // Index 0 is the upstream port; index i+1 is the output of stage i.
  logic             valid_c [DEPTH+1];
  logic             ready_c [DEPTH+1];
  logic [WIDTH-1:0] data_c  [DEPTH+1];
  logic [LVL_W-1:0] level_c;

  assign valid_c[0]     = in_valid;
  assign data_c[0]      = in_data;
  assign ready_c[DEPTH] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      ffd_pipe_stage #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .d_valid (valid_c[gi]),
        .d_data  (data_c[gi]),
        .d_ready (ready_c[gi]),
        .q_valid (valid_c[gi+1]),
        .q_data  (data_c[gi+1]),
        .q_ready (ready_c[gi+1])
      );
    end
  endgenerate

  // Handshakes are masked so nothing transfers while flush or reset is active.
  assign in_ready  = ready_c[0] & ~flush & ~rstn;
  assign out_valid = valid_c[DEPTH] & ~flush & ~rstn;
  assign out_data  = data_c[DEPTH];

  always_comb begin
    level_c = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      level_c = level_c + LVL_W'(valid_c[i]);
    end
  end

  assign level = level_c;

endmodule

// File: tb/tb_ffd_pipe.sv
// Directed table-driven bench for ffd_pipe, with two instances: data cleared
// by reset (a) and data held through reset (b), both fed the same stimulus.
module tb_ffd_pipe;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0] a_out_data, b_out_data;
  logic [2:0] a_level, b_level;

  always #5 clk = ~clk;

  ffd_pipe #(.WIDTH(8), .DEPTH(4), .CLEAR_DATA(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .level(a_level)
  );

  ffd_pipe #(.WIDTH(8), .DEPTH(4), .CLEAR_DATA(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .level(b_level)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ord;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_lvl;
    logic       chk;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] id,
                     input logic ord, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input logic [2:0] e_lvl, input logic chk);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ord = ord;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl; v.chk = chk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       found;

    // Reset: two edges held, then release
    add(1,0,0,8'h00,0, 0,0,8'h00,0,1);
    add(1,0,0,8'h00,0, 0,0,8'h00,0,1);
    add(0,0,0,8'h00,0, 1,0,8'h00,0,1);
    // Streaming 01..08 with out_ready=1
    add(0,0,1,8'h01,1, 1,0,8'h00,0,0);
    add(0,0,1,8'h02,1, 1,0,8'h00,1,0);
    add(0,0,1,8'h03,1, 1,0,8'h00,2,0);
    add(0,0,1,8'h04,1, 1,0,8'h00,3,0);
    add(0,0,1,8'h05,1, 1,1,8'h01,4,1);
    add(0,0,1,8'h06,1, 1,1,8'h02,4,1);
    add(0,0,1,8'h07,1, 1,1,8'h03,4,1);
    add(0,0,1,8'h08,1, 1,1,8'h04,4,1);
    add(0,0,0,8'h00,1, 1,1,8'h05,4,1);
    add(0,0,0,8'h00,1, 1,1,8'h06,3,1);
    add(0,0,0,8'h00,1, 1,1,8'h07,2,1);
    add(0,0,0,8'h00,1, 1,1,8'h08,1,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,0,0);
    // Backpressure A0..A5, A4 held while stalled
    add(0,0,1,8'hA0,0, 1,0,8'h00,0,0);
    add(0,0,1,8'hA1,0, 1,0,8'h00,1,0);
    add(0,0,1,8'hA2,0, 1,0,8'h00,2,0);
    add(0,0,1,8'hA3,0, 1,0,8'h00,3,0);
    add(0,0,1,8'hA4,0, 0,1,8'hA0,4,1);
    add(0,0,1,8'hA4,0, 0,1,8'hA0,4,1);
    add(0,0,1,8'hA4,1, 1,1,8'hA0,4,1);
    add(0,0,1,8'hA5,1, 1,1,8'hA1,4,1);
    add(0,0,0,8'h00,1, 1,1,8'hA2,4,1);
    add(0,0,0,8'h00,1, 1,1,8'hA3,3,1);
    add(0,0,0,8'h00,1, 1,1,8'hA4,2,1);
    add(0,0,0,8'h00,1, 1,1,8'hA5,1,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,0,0);
    // Bubble collapse: 11, two idles, 22, stalled then released
    add(0,0,1,8'h11,0, 1,0,8'h00,0,0);
    add(0,0,0,8'h00,0, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,0,8'h00,1,0);
    add(0,0,1,8'h22,0, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,1,8'h11,2,1);
    add(0,0,0,8'h00,0, 1,1,8'h11,2,1);
    add(0,0,0,8'h00,0, 1,1,8'h11,2,1);
    add(0,0,0,8'h00,1, 1,1,8'h11,2,1);
    add(0,0,0,8'h00,1, 1,1,8'h22,1,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,0,0);
    // Flush at level 3 with a word offered; the word is lost, data holds
    add(0,0,1,8'h31,0, 1,0,8'h00,0,0);
    add(0,0,0,8'h00,0, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,0, 1,0,8'h00,1,0);
    add(0,0,1,8'h32,0, 1,0,8'h00,1,0);
    add(0,0,1,8'h33,0, 1,1,8'h31,2,1);
    add(0,1,1,8'h34,0, 0,0,8'h00,3,0);
    add(0,0,0,8'h00,0, 1,0,8'h31,0,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,0,0);
    // Mid-stream reset while full, then 5A traverses an empty pipe
    add(0,0,1,8'h61,0, 1,0,8'h00,0,0);
    add(0,0,1,8'h62,0, 1,0,8'h00,1,0);
    add(0,0,1,8'h63,0, 1,0,8'h00,2,0);
    add(0,0,1,8'h64,0, 1,0,8'h00,3,0);
    add(0,0,1,8'h65,0, 0,1,8'h61,4,1);
    add(1,0,0,8'h00,0, 0,0,8'h00,4,0);
    add(0,0,1,8'h5A,1, 1,0,8'h00,0,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,1, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,1, 1,0,8'h00,1,0);
    add(0,0,0,8'h00,1, 1,1,8'h5A,1,1);
    add(0,0,0,8'h00,1, 1,0,8'h00,0,0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rstn = vecs[k].rst; flush = vecs[k].fl; in_valid = vecs[k].iv;
      in_data = vecs[k].id; out_ready = vecs[k].ord;
      #1;
      $display("[TB] vec %0d: in %h/%0b ir=%0b ov=%0b od=%h lvl=%0d", k,
               in_data, in_valid, a_in_ready, a_out_valid, a_out_data, a_level);
      check($sformatf("v%0d a_in_ready", k), {7'd0, a_in_ready}, {7'd0, vecs[k].e_ir});
      check($sformatf("v%0d a_out_valid", k), {7'd0, a_out_valid}, {7'd0, vecs[k].e_ov});
      check($sformatf("v%0d a_level", k), {5'd0, a_level}, {5'd0, vecs[k].e_lvl});
      if (vecs[k].chk) check($sformatf("v%0d a_out_data", k), a_out_data, vecs[k].e_od);
      check($sformatf("v%0d b_in_ready", k), {7'd0, b_in_ready}, {7'd0, vecs[k].e_ir});
      check($sformatf("v%0d b_out_valid", k), {7'd0, b_out_valid}, {7'd0, vecs[k].e_ov});
      check($sformatf("v%0d b_level", k), {5'd0, b_level}, {5'd0, vecs[k].e_lvl});
      if (vecs[k].chk && vecs[k].e_ov)
        check($sformatf("v%0d b_out_data", k), b_out_data, vecs[k].e_od);
    end

    // Reset with CLEAR_DATA=0 keeps stale data but never presents it as valid
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rstn = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1 + 8'(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    $display("[TB] full before reset: b ov=%0b od=%h lvl=%0d", b_out_valid, b_out_data, b_level);
    check("hold b_out_valid_full", {7'd0, b_out_valid}, 8'd1);
    check("hold b_out_data_full", b_out_data, 8'hC1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    $display("[TB] after reset: a od=%h b ov=%0b od=%h lvl=%0d", a_out_data, b_out_valid, b_out_data, b_level);
    check("hold b_out_data_kept", b_out_data, 8'hC1);
    check("hold a_out_data_clr", a_out_data, 8'h00);
    check("hold b_out_valid", {7'd0, b_out_valid}, 8'd0);
    check("hold b_level", {5'd0, b_level}, 8'd0);

    // Latency of a single word with out_ready high, bounded wait
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    check("lat in_ready", {7'd0, a_in_ready}, 8'd1);
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (a_out_valid) begin
        found = 1'b1;
        lat = k;
      end
    end
    $display("[TB] latency word 77: found=%0b cycles=%0d data=%h", found, lat, a_out_data);
    check("lat found", {7'd0, found}, 8'd1);
    check("lat cycles", 8'(lat), 8'd4);
    check("lat data", a_out_data, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
